// File: rtl/braille_pkg.sv
// Shared definitions for the braille LED presenter.
//   state_t         : presenter FSM states.
//   PAT_A .. PAT_Z  : 6-bit braille cells, bit n-1 = dot n.
//   PAT_ERR         : all six dots raised, shown for out-of-range indices.
//   letter_pattern(): class index (0 = a) to cell pattern.
package braille_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SHOW_L = 3'd1,
    GAP_L  = 3'd2,
    SHOW_R = 3'd3,
    GAP_R  = 3'd4
  } state_t;

  // First decade: dots 1,2,4,5 only.
  localparam logic [5:0] PAT_A = 6'h01;
  localparam logic [5:0] PAT_B = 6'h03;
  localparam logic [5:0] PAT_C = 6'h09;
  localparam logic [5:0] PAT_D = 6'h19;
  localparam logic [5:0] PAT_E = 6'h11;
  localparam logic [5:0] PAT_F = 6'h0B;
  localparam logic [5:0] PAT_G = 6'h1B;
  localparam logic [5:0] PAT_H = 6'h13;
  localparam logic [5:0] PAT_I = 6'h0A;
  localparam logic [5:0] PAT_J = 6'h1A;
  // Second decade: first decade plus dot 3.
  localparam logic [5:0] PAT_K = PAT_A | 6'h04;
  localparam logic [5:0] PAT_L = PAT_B | 6'h04;
  localparam logic [5:0] PAT_M = PAT_C | 6'h04;
  localparam logic [5:0] PAT_N = PAT_D | 6'h04;
  localparam logic [5:0] PAT_O = PAT_E | 6'h04;
  localparam logic [5:0] PAT_P = PAT_F | 6'h04;
  localparam logic [5:0] PAT_Q = PAT_G | 6'h04;
  localparam logic [5:0] PAT_R = PAT_H | 6'h04;
  localparam logic [5:0] PAT_S = PAT_I | 6'h04;
  localparam logic [5:0] PAT_T = PAT_J | 6'h04;
  // Third decade: first decade plus dots 3 and 6; w is irregular.
  localparam logic [5:0] PAT_U = PAT_A | 6'h24;
  localparam logic [5:0] PAT_V = PAT_B | 6'h24;
  localparam logic [5:0] PAT_W = 6'h3A;
  localparam logic [5:0] PAT_X = PAT_C | 6'h24;
  localparam logic [5:0] PAT_Y = PAT_D | 6'h24;
  localparam logic [5:0] PAT_Z = PAT_E | 6'h24;

  localparam logic [5:0] PAT_ERR = 6'h3F;

  function automatic logic [5:0] letter_pattern(input int unsigned idx);
    logic [5:0] pat;
    case (idx)
      0:       pat = PAT_A;
      1:       pat = PAT_B;
      2:       pat = PAT_C;
      3:       pat = PAT_D;
      4:       pat = PAT_E;
      5:       pat = PAT_F;
      6:       pat = PAT_G;
      7:       pat = PAT_H;
      8:       pat = PAT_I;
      9:       pat = PAT_J;
      10:      pat = PAT_K;
      11:      pat = PAT_L;
      12:      pat = PAT_M;
      13:      pat = PAT_N;
      14:      pat = PAT_O;
      15:      pat = PAT_P;
      16:      pat = PAT_Q;
      17:      pat = PAT_R;
      18:      pat = PAT_S;
      19:      pat = PAT_T;
      20:      pat = PAT_U;
      21:      pat = PAT_V;
      22:      pat = PAT_W;
      23:      pat = PAT_X;
      24:      pat = PAT_Y;
      25:      pat = PAT_Z;
      default: pat = PAT_ERR;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/braille_encoder.sv
// Combinational class-index to braille-cell encoder.
//   alpha_i   : class index from the classifier.
//   pattern_o : 6-bit cell, bit n-1 = dot n (all dots for invalid indices).
//   err_o     : index is outside 0..NUM_CLASSES-1.
module braille_encoder
  import braille_pkg::*;
#(
  parameter int ALPHA_BW    = 5,
  parameter int NUM_CLASSES = 26
) (
  input  logic [ALPHA_BW-1:0] alpha_i,
  output logic [5:0]          pattern_o,
  output logic                err_o
);

  localparam int unsigned NUM_CLASSES_U = NUM_CLASSES;

  int unsigned idx;

  always_comb begin
    idx       = 32'(alpha_i);
    err_o     = (idx >= NUM_CLASSES_U);
    pattern_o = err_o ? PAT_ERR : letter_pattern(idx);
  end

endmodule

// File: rtl/braille_led_presenter.sv
// Presents classifier results as braille cells on three LEDs.
// Each cell is shown as: left column (dots 1-3), blank gap, right column
// (dots 4-6), blank gap. One further result can wait in a pending slot.
//   clk, reset   : clock, asynchronous active-high reset.
//   i_valid      : one-cycle result strobe; i_alpha valid with it.
//   i_alpha      : class index (0 = a).
//   led          : top/middle/bottom dot of the column currently shown.
//   o_col        : 0 while left column or its gap, 1 for right column/gap.
//   o_busy       : a cell is being presented.
//   o_err        : current cell comes from an out-of-range index.
//   o_done       : pulse on the final cycle of a cell.
//   o_overflow   : pulse when a result is dropped because the slot is full.
module braille_led_presenter
  import braille_pkg::*;
#(
  parameter int ALPHA_BW    = 5,
  parameter int NUM_CLASSES = 26,
  parameter int COL_CYCLES  = 100_000_000,
  parameter int GAP_CYCLES  = 25_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [ALPHA_BW-1:0] i_alpha,
  output logic [2:0]          led,
  output logic                o_col,
  output logic                o_busy,
  output logic                o_err,
  output logic                o_done,
  output logic                o_overflow
);

  // COL_CYCLES and GAP_CYCLES must both be at least 1.
  localparam int MAX_CYCLES = (COL_CYCLES > GAP_CYCLES) ? COL_CYCLES : GAP_CYCLES;
  localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(COL_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYCLES - 1);

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [5:0]          pat_q, pat_d;
  logic                err_q, err_d;
  logic                pend_valid_q, pend_valid_d;
  logic [ALPHA_BW-1:0] pend_alpha_q, pend_alpha_d;

  logic [2:0]          led_q, led_d;
  logic                col_q, col_d;
  logic                busy_q, busy_d;
  logic                err_out_q, err_out_d;
  logic                done_q, done_d;
  logic                ovf_q, ovf_d;

  logic                cell_end;
  logic                take_pend;
  logic [ALPHA_BW-1:0] enc_alpha;
  logic [5:0]          enc_pattern;
  logic                enc_err;
  logic                load;

  // Last cycle of the cell; the follow-on decision is made here.
  assign cell_end  = (state_q == GAP_R) && (cnt_q == GAP_LAST);
  // The pending result always has priority over a simultaneous new one.
  assign take_pend = cell_end && pend_valid_q;
  assign enc_alpha = take_pend ? pend_alpha_q : i_alpha;

  braille_encoder #(
    .ALPHA_BW   (ALPHA_BW),
    .NUM_CLASSES(NUM_CLASSES)
  ) u_encoder (
    .alpha_i  (enc_alpha),
    .pattern_o(enc_pattern),
    .err_o    (enc_err)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + CW'(1);
    pat_d        = pat_q;
    err_d        = err_q;
    pend_valid_d = pend_valid_q;
    pend_alpha_d = pend_alpha_q;
    ovf_d        = 1'b0;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (i_valid) begin
          load    = 1'b1;
          state_d = SHOW_L;
        end
      end
      SHOW_L: begin
        if (cnt_q == COL_LAST) begin
          state_d = GAP_L;
          cnt_d   = '0;
        end
      end
      GAP_L: begin
        if (cnt_q == GAP_LAST) begin
          state_d = SHOW_R;
          cnt_d   = '0;
        end
      end
      SHOW_R: begin
        if (cnt_q == COL_LAST) begin
          state_d = GAP_R;
          cnt_d   = '0;
        end
      end
      GAP_R: begin
        if (cell_end) begin
          cnt_d = '0;
          if (pend_valid_q) begin
            load         = 1'b1;
            state_d      = SHOW_L;
            pend_valid_d = 1'b0;
          end else if (i_valid) begin
            load    = 1'b1;
            state_d = SHOW_L;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // A result arriving while busy goes to the pending slot unless it is
    // being displayed directly. When the slot is emptied this same cycle the
    // newcomer refills it, so that case never counts as an overflow.
    if (i_valid && (state_q != IDLE) && !(load && !take_pend)) begin
      if (!pend_valid_q || take_pend) begin
        pend_valid_d = 1'b1;
        pend_alpha_d = i_alpha;
      end else begin
        ovf_d = 1'b1;
      end
    end

    if (load) begin
      pat_d = enc_pattern;
      err_d = enc_err;
    end

    // Outputs are derived from next-state values so they are registered
    // yet line up with the state they describe.
    led_d     = 3'b000;
    if (state_d == SHOW_L) led_d = pat_d[2:0];
    if (state_d == SHOW_R) led_d = pat_d[5:3];
    col_d     = (state_d == SHOW_R) || (state_d == GAP_R);
    busy_d    = (state_d != IDLE);
    err_out_d = busy_d && err_d;
    done_d    = (state_d == GAP_R) && (cnt_d == GAP_LAST);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      pat_q        <= '0;
      err_q        <= 1'b0;
      pend_valid_q <= 1'b0;
      pend_alpha_q <= '0;
      led_q        <= 3'b000;
      col_q        <= 1'b0;
      busy_q       <= 1'b0;
      err_out_q    <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pat_q        <= pat_d;
      err_q        <= err_d;
      pend_valid_q <= pend_valid_d;
      pend_alpha_q <= pend_alpha_d;
      led_q        <= led_d;
      col_q        <= col_d;
      busy_q       <= busy_d;
      err_out_q    <= err_out_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

  assign led        = led_q;
  assign o_col      = col_q;
  assign o_busy     = busy_q;
  assign o_err      = err_out_q;
  assign o_done     = done_q;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_braille_led_presenter.sv
module tb_braille_led_presenter;

  localparam int COL = 4;
  localparam int GAP = 2;
  localparam int CELL = 2 * (COL + GAP);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_valid = 1'b0;
  logic [4:0] i_alpha = '0;
  logic [2:0] led;
  logic       o_col, o_busy, o_err, o_done, o_overflow;

  braille_led_presenter #(
    .ALPHA_BW   (5),
    .NUM_CLASSES(26),
    .COL_CYCLES (COL),
    .GAP_CYCLES (GAP)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (i_valid),
    .i_alpha   (i_alpha),
    .led       (led),
    .o_col     (o_col),
    .o_busy    (o_busy),
    .o_err     (o_err),
    .o_done    (o_done),
    .o_overflow(o_overflow)
  );

  always #5 clk = ~clk;

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int alpha;
    int start_e;
  } cell_t;

  cell_t sb_q[$];
  int    ovf_q[$];
  bit    mon_en = 1'b0;

  // Reference cell from the letter rules: three decades built from a..j.
  function automatic logic [5:0] ref_pattern(input int idx);
    logic [5:0] base [10];
    int b;
    base = '{6'h01, 6'h03, 6'h09, 6'h19, 6'h11, 6'h0B, 6'h1B, 6'h13, 6'h0A, 6'h1A};
    if (idx >= 26) return 6'h3F;
    if (idx < 10) return base[idx];
    if (idx < 20) return base[idx - 10] | 6'h04;
    if (idx == 22) return 6'h3A;
    b = idx - 20 - ((idx > 22) ? 1 : 0);
    return base[b] | 6'h24;
  endfunction

  // Expected {led, col, busy, err, done} at a position inside a cell.
  function automatic logic [6:0] ref_outputs(input int idx, input int p);
    logic [5:0] pat;
    logic [2:0] l;
    logic       c;
    pat = ref_pattern(idx);
    l   = 3'b000;
    c   = (p >= COL + GAP);
    if (p < COL) l = pat[2:0];
    else if (p >= COL + GAP && p < 2 * COL + GAP) l = pat[5:3];
    return {l, c, 1'b1, (idx >= 26), (p == CELL - 1)};
  endfunction

  // ---------------- behavioural model (edge-indexed timeline) ----------------
  bit m_active = 0;
  bit m_pend = 0;
  int m_pend_a = 0;
  int m_end_e = 0;
  int last_j = 0;

  task automatic m_start(input int a, input int j);
    cell_t c;
    c.alpha   = a;
    c.start_e = j;
    sb_q.push_back(c);
    m_active = 1;
    m_end_e  = j + CELL;
  endtask

  task automatic model(input bit v, input int a, input int j);
    if (m_active && j == m_end_e) begin
      if (m_pend) begin
        m_start(m_pend_a, j);
        m_pend = v;
        if (v) m_pend_a = a;
      end else if (v) begin
        m_start(a, j);
      end else begin
        m_active = 0;
      end
    end else if (m_active) begin
      if (v) begin
        if (!m_pend) begin
          m_pend   = 1;
          m_pend_a = a;
        end else begin
          ovf_q.push_back(j);
        end
      end
    end else if (v) begin
      m_start(a, j);
    end
  endtask

  task automatic model_clear();
    m_active = 0;
    m_pend   = 0;
    sb_q.delete();
    ovf_q.delete();
  endtask

  task automatic step(input bit v, input int a);
    int j;
    @(negedge clk);
    j = edge_n + 1;
    i_valid = v;
    i_alpha = 5'(a);
    model(v, a, j);
    last_j = j;
    if (v) $display("edge %0d: drive i_alpha=%0d", j, a);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit         in_cell;
    bit         busy_prev;
    bit         done_prev;
    int         phase;
    int         cur_a;
    cell_t      exp_c;
    logic [6:0] exp_v;
    logic [6:0] act_v;
    in_cell = 0; busy_prev = 0; done_prev = 0; phase = 0; cur_a = 0;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        in_cell = 0; busy_prev = 0; done_prev = 0;
      end else begin
        if (o_busy && (!busy_prev || done_prev)) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL cell_start: got unexpected cell at edge %0d, required none", edge_n);
            cur_a = 0;
          end else begin
            exp_c = sb_q.pop_front();
            cur_a = exp_c.alpha;
            if (exp_c.start_e != edge_n) begin
              errors++;
              $display("FAIL cell_start: got start edge %0d, required %0d (alpha %0d)",
                       edge_n, exp_c.start_e, exp_c.alpha);
            end else begin
              $display("edge %0d: cell alpha=%0d started", edge_n, cur_a);
            end
          end
          in_cell = 1;
          phase   = 0;
        end
        exp_v = in_cell ? ref_outputs(cur_a, phase) : 7'b0;
        act_v = {led, o_col, o_busy, o_err, o_done};
        checks++;
        if (act_v !== exp_v) begin
          errors++;
          $display("FAIL outputs: edge %0d alpha %0d phase %0d got led/col/busy/err/done=%b required %b",
                   edge_n, cur_a, phase, act_v, exp_v);
        end
        if (o_overflow) begin
          checks++;
          if (ovf_q.size() == 0 || ovf_q[0] != edge_n) begin
            errors++;
            $display("FAIL overflow: got pulse at edge %0d, required %0d", edge_n,
                     (ovf_q.size() == 0) ? -1 : ovf_q[0]);
          end else begin
            $display("edge %0d: overflow pulse", edge_n);
          end
          if (ovf_q.size() != 0 && ovf_q[0] <= edge_n) void'(ovf_q.pop_front());
        end else if (ovf_q.size() != 0 && ovf_q[0] <= edge_n) begin
          checks++;
          errors++;
          $display("FAIL overflow: got no pulse at edge %0d, required pulse", edge_n);
          void'(ovf_q.pop_front());
        end
        busy_prev = o_busy;
        done_prev = o_done;
        if (in_cell) begin
          phase++;
          if (phase == CELL) in_cell = 0;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin : stimulus
    int guard;
    repeat (3) @(negedge clk);
    checks++;
    if ({led, o_col, o_busy, o_err, o_done, o_overflow} !== 8'b0) begin
      errors++;
      $display("FAIL reset_state: got %b required 00000000",
               {led, o_col, o_busy, o_err, o_done, o_overflow});
    end
    reset  = 1'b0;
    mon_en = 1'b1;

    // Start a cell, park a second one, then reset while in the right column.
    step(1, 5);
    step(0, 0);
    step(1, 9);
    repeat (7) step(0, 0);
    #1;
    reset   = 1'b1;
    mon_en  = 1'b0;
    i_valid = 1'b0;
    #1;
    checks++;
    if (led !== 3'b000) begin
      errors++;
      $display("FAIL async_reset_led: got %b required 000", led);
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL async_reset_busy: got %b required 0", o_busy);
    end
    model_clear();
    repeat (2) @(negedge clk);
    reset  = 1'b0;
    mon_en = 1'b1;

    // Directed letters: d, w, u, out-of-range.
    step(1, 3);  repeat (CELL + 2) step(0, 0);
    step(1, 22); repeat (CELL + 2) step(0, 0);
    step(1, 20); repeat (CELL + 2) step(0, 0);
    step(1, 30); repeat (CELL + 2) step(0, 0);

    // Back-to-back a then b, third pulse overflows.
    step(1, 0);
    step(0, 0);
    step(1, 1);
    repeat (3) step(0, 0);
    step(1, 7);

    // New result on the final right-gap cycle with an empty slot.
    guard = 0;
    while (!(m_active && !m_pend && last_j + 1 == m_end_e) && guard < 100) begin
      step(0, 0);
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL align_gap_r: got no aligned edge within %0d steps, required alignment", guard);
    end
    step(1, 4);
    repeat (CELL + 2) step(0, 0);

    // Randomised traffic.
    repeat (2000) begin
      if ($urandom_range(0, 9) == 0) step(1, int'($urandom_range(0, 31)));
      else step(0, 0);
    end
    repeat (2 * CELL + 6) step(0, 0);

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL cells_left: got %0d unseen cells, required 0", sb_q.size());
    end
    checks++;
    if (ovf_q.size() != 0) begin
      errors++;
      $display("FAIL overflows_left: got %0d unseen overflows, required 0", ovf_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
